uart_peripheral: RTL and testbench

- Memory-mapped UART with a TX FIFO and a single-entry RX holding register. It sits in the peripheral region behind the peripheral bus decoder.
- It drives the UART_TX pin, samples the UART_RX pin, and raises one interrupt line into the PLIC using a req/ack handshake.
- Read data is registered, giving 1-cycle latency. This matches the registered response-select mux on the CPU data path.

---
 rtl/RS5_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 46 ++++
 rtl/uart_peripheral.sv | 238 +++++++++++++++++++++++
 tb/tb_uart_peripheral.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/RS5_pkg.sv
// Shared definitions for the UART peripheral: FSM state encoding and register offsets.
package RS5_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_RXDATA = 2'd1;
    localparam logic [1:0] UART_STATUS = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide circular TX FIFO; the pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo
    import RS5_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wrPtr;
    logic [AW:0] r_rdPtr;
    logic [7:0]  r_mem [DEPTH];
    logic        w_doPush;
    logic        w_doPop;

    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign w_doPush = i_push & ~o_full;
    assign w_doPop  = i_pop & ~o_empty;
    assign o_data   = r_mem[r_rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + (AW+1)'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_peripheral.sv
// Memory-mapped UART: TX FIFO feeding a TX FSM, synchronized RX FSM with a single holding
// register, and a req/ack interrupt toward the PLIC.
module uart_peripheral
    import RS5_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TX_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        irq_o,
    input  logic        iack_i,
    input  logic        uart_rx_i,
    output logic        uart_tx_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

    logic [1:0]  w_sel;
    logic        w_read;
    logic        w_txWrite;
    logic        w_rxRead;
    logic        w_statusRead;
    logic        w_fifoFull;
    logic        w_fifoEmpty;
    logic [7:0]  w_fifoData;
    logic        w_txPop;
    logic        w_rxIn;
    logic        w_rxDone;
    logic        w_unused;

    uart_state_e r_txState;
    logic [CW-1:0] r_txCnt;
    logic [2:0]  r_txBit;
    logic [7:0]  r_txShift;
    logic        r_txLine;

    logic        r_rxSync1;
    logic        r_rxSync2;
    uart_state_e r_rxState;
    logic [CW-1:0] r_rxCnt;
    logic [2:0]  r_rxBit;
    logic [7:0]  r_rxShift;
    logic [7:0]  r_rxByte;
    logic        r_rxValid;
    logic        r_overrun;

    logic        r_irqEn;
    logic        r_irq;
    logic [31:0] r_rdata;

    assign w_sel        = addr_i[3:2];
    assign w_read       = en_i & (we_i == 4'b0000);
    assign w_txWrite    = en_i & we_i[0] & (w_sel == UART_TXDATA);
    assign w_rxRead     = w_read & (w_sel == UART_RXDATA);
    assign w_statusRead = w_read & (w_sel == UART_STATUS);
    assign w_txPop      = (r_txState == IDLE) & ~w_fifoEmpty;
    assign w_rxIn       = r_rxSync2;
    assign w_rxDone     = (r_rxState == STOP) & (r_rxCnt == BIT_LAST) & w_rxIn;
    assign w_unused     = ^{addr_i[1:0], data_i[31:8]};

    // The FIFO refuses a push while full, so the CPU simply holds the request until it lands.
    assign stall_o   = w_txWrite & w_fifoFull;
    assign data_o    = r_rdata;
    assign irq_o     = r_irq;
    assign uart_tx_o = r_txLine;

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_txFifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_txWrite),
        .i_pop   (w_txPop),
        .i_data  (data_i[7:0]),
        .o_data  (w_fifoData),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_txState <= IDLE;
            r_txCnt   <= '0;
            r_txBit   <= '0;
            r_txShift <= '0;
            r_txLine  <= 1'b1;
        end else begin
            case (r_txState)
                IDLE: begin
                    if (!w_fifoEmpty) begin
                        r_txShift <= w_fifoData;
                        r_txCnt   <= '0;
                        r_txBit   <= '0;
                        r_txLine  <= 1'b0;
                        r_txState <= START;
                    end
                end
                START: begin
                    if (r_txCnt == BIT_LAST) begin
                        r_txCnt   <= '0;
                        r_txLine  <= r_txShift[0];
                        r_txState <= DATA;
                    end else begin
                        r_txCnt <= r_txCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_txCnt == BIT_LAST) begin
                        r_txCnt <= '0;
                        if (r_txBit == 3'd7) begin
                            r_txLine  <= 1'b1;
                            r_txState <= STOP;
                        end else begin
                            r_txShift <= {1'b0, r_txShift[7:1]};
                            r_txLine  <= r_txShift[1];
                            r_txBit   <= r_txBit + 3'd1;
                        end
                    end else begin
                        r_txCnt <= r_txCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_txCnt == BIT_LAST) begin
                        r_txCnt   <= '0;
                        r_txState <= IDLE;
                    end else begin
                        r_txCnt <= r_txCnt + CW'(1);
                    end
                end
                default: r_txState <= IDLE;
            endcase
        end
    end

    // The RX pin is asynchronous; everything downstream looks only at the second flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
        end else begin
            r_rxSync1 <= uart_rx_i;
            r_rxSync2 <= r_rxSync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rxState <= IDLE;
            r_rxCnt   <= '0;
            r_rxBit   <= '0;
            r_rxShift <= '0;
            r_rxByte  <= '0;
            r_rxValid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_rxState)
                IDLE: begin
                    if (!w_rxIn) begin
                        r_rxCnt   <= '0;
                        r_rxState <= START;
                    end
                end
                START: begin
                    if (r_rxCnt == BIT_HALF) begin
                        r_rxCnt   <= '0;
                        r_rxBit   <= '0;
                        r_rxState <= w_rxIn ? IDLE : DATA;
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                DATA: begin
                    if (r_rxCnt == BIT_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxShift <= {w_rxIn, r_rxShift[7:1]};
                        r_rxBit   <= r_rxBit + 3'd1;
                        if (r_rxBit == 3'd7) r_rxState <= STOP;
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                STOP: begin
                    if (r_rxCnt == BIT_LAST) begin
                        r_rxCnt   <= '0;
                        r_rxState <= IDLE;
                    end else begin
                        r_rxCnt <= r_rxCnt + CW'(1);
                    end
                end
                default: r_rxState <= IDLE;
            endcase

            // A completing byte beats a simultaneous RXDATA read, so the new byte stays valid.
            if (w_rxDone) begin
                r_rxByte  <= r_rxShift;
                r_rxValid <= 1'b1;
            end else if (w_rxRead) begin
                r_rxValid <= 1'b0;
            end

            if (w_rxDone && r_rxValid) r_overrun <= 1'b1;
            else if (w_statusRead)     r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irqEn <= 1'b0;
            r_irq   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (en_i && (w_sel == UART_CTRL) && we_i[0]) r_irqEn <= data_i[0];

            if (w_rxDone && r_irqEn) r_irq <= 1'b1;
            else if (iack_i)         r_irq <= 1'b0;

            if (w_read) begin
                case (w_sel)
                    UART_RXDATA: r_rdata <= {r_rxValid, 23'b0, r_rxByte};
                    UART_STATUS: r_rdata <= {27'b0, (r_txState != IDLE), r_overrun, r_rxValid,
                                             w_fifoEmpty, w_fifoFull};
                    UART_CTRL:   r_rdata <= {31'b0, r_irqEn};
                    default:     r_rdata <= '0;
                endcase
            end else begin
                r_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_peripheral.sv
// Self-checking bench for uart_peripheral: register vectors, a TX scoreboard fed by a line
// decoder, and hand-timed RX, interrupt and reset sequences.
module tb_uart_peripheral;
    import RS5_pkg::*;

    localparam int CLKS  = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CLKS + 1;

    localparam logic [3:0] A_TX   = 4'h0;
    localparam logic [3:0] A_RX   = 4'h4;
    localparam logic [3:0] A_STAT = 4'h8;
    localparam logic [3:0] A_CTRL = 4'hC;

    typedef struct packed {
        logic        isWrite;
        logic [3:0]  we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expData;
    } vector_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en_i = 1'b0;
    logic [3:0]  we_i = 4'h0;
    logic [3:0]  addr_i = 4'h0;
    logic [31:0] data_i = 32'h0;
    logic        iack_i = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic [31:0] data_o;
    logic        stall_o;
    logic        irq_o;
    logic        uart_tx_o;

    int nChecks = 0;
    int nFailures = 0;
    int cycleCount = 0;
    logic [7:0] txExpect[$];
    int txStartLog[$];

    uart_peripheral #(.CLKS_PER_BIT(CLKS), .TX_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .en_i      (en_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .stall_o   (stall_o),
        .irq_o     (irq_o),
        .iack_i    (iack_i),
        .uart_rx_i (uart_rx_i),
        .uart_tx_o (uart_tx_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFailures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One bus access starting on a negedge; holds the request while stall_o is high.
    task automatic applyStimulus(input logic isWrite, input logic [3:0] we, input logic [3:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int stallCycles);
        stallCycles = 0;
        en_i   = 1'b1;
        we_i   = isWrite ? we : 4'h0;
        addr_i = addr;
        data_i = wdata;
        #1;
        while (stall_o && stallCycles < 200) begin
            stallCycles++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        en_i   = 1'b0;
        we_i   = 4'h0;
        addr_i = 4'h0;
        data_i = 32'h0;
        rdata  = data_o;
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [31:0] wdata, output int stalls);
        logic [31:0] unusedRd;
        applyStimulus(1'b1, 4'hF, addr, wdata, unusedRd, stalls);
    endtask

    task automatic busRead(input logic [3:0] addr, output logic [31:0] rd);
        int unusedStalls;
        applyStimulus(1'b0, 4'h0, addr, 32'h0, rd, unusedStalls);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseAck();
        iack_i = 1'b1;
        @(negedge clk);
        iack_i = 1'b0;
    endtask

    task automatic sendRxFrame(input logic [7:0] b, input logic stopBit);
        uart_rx_i = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            repeat (CLKS) @(negedge clk);
        end
        uart_rx_i = stopBit;
        repeat (CLKS) @(negedge clk);
        uart_rx_i = 1'b1;
    endtask

    task automatic waitTxDrain(input string name, input int limit);
        for (int i = 0; i < limit && txExpect.size() != 0; i++) @(negedge clk);
        checkOutput(name, txExpect.size(), 32'd0);
    endtask

    // Decodes frames on uart_tx_o mid-bit and scores them against the expected queue.
    initial begin : txMonitor
        logic [7:0] got;
        logic       stopSeen;
        logic       aborted;
        int         startCycle;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (reset && uart_tx_o == 1'b0) begin
                startCycle = cycleCount;
                aborted    = 1'b0;
                got        = 8'h00;
                stopSeen   = 1'b0;
                for (int c = 1; c <= 9 * CLKS + 2; c++) begin
                    @(negedge clk);
                    if (!reset) aborted = 1'b1;
                    if (c >= 6 && c <= 34 && (c % 4) == 2) got[(c - 6) / 4] = uart_tx_o;
                    if (c == 38) stopSeen = uart_tx_o;
                end
                if (!aborted) begin
                    txStartLog.push_back(startCycle);
                    if (txExpect.size() == 0) begin
                        nChecks++;
                        nFailures++;
                        $display("[TB] FAIL txUnexpected: got byte 0x%02h, expected no frame", got);
                    end else begin
                        exp = txExpect.pop_front();
                        checkOutput("txByte", {24'b0, got}, {24'b0, exp});
                    end
                    checkOutput("txStopBit", {31'b0, stopSeen}, 32'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin : mainTest
        vector_t     regVectors[17];
        logic [31:0] rd;
        int          stalls[6];
        int          st;
        logic [7:0]  burst[6];

        regVectors[0]  = '{1'b0, 4'h0, A_TX,   32'h0,        32'h0};
        regVectors[1]  = '{1'b0, 4'h0, A_RX,   32'h0,        32'h0};
        regVectors[2]  = '{1'b0, 4'h0, A_STAT, 32'h0,        32'h2};
        regVectors[3]  = '{1'b0, 4'h0, A_CTRL, 32'h0,        32'h0};
        regVectors[4]  = '{1'b1, 4'hF, A_CTRL, 32'h1,        32'h0};
        regVectors[5]  = '{1'b0, 4'h0, A_CTRL, 32'h0,        32'h1};
        regVectors[6]  = '{1'b1, 4'hE, A_CTRL, 32'h0,        32'h0};
        regVectors[7]  = '{1'b0, 4'h0, A_CTRL, 32'h0,        32'h1};
        regVectors[8]  = '{1'b1, 4'hF, A_RX,   32'hFFFFFFFF, 32'h0};
        regVectors[9]  = '{1'b0, 4'h0, A_RX,   32'h0,        32'h0};
        regVectors[10] = '{1'b0, 4'h0, A_STAT, 32'h0,        32'h2};
        regVectors[11] = '{1'b1, 4'h1, A_CTRL, 32'h0,        32'h0};
        regVectors[12] = '{1'b0, 4'h0, A_CTRL, 32'h0,        32'h0};
        regVectors[13] = '{1'b1, 4'hE, A_TX,   32'h77,       32'h0};
        regVectors[14] = '{1'b0, 4'h0, A_STAT, 32'h0,        32'h2};
        regVectors[15] = '{1'b1, 4'hF, A_STAT, 32'hFF,       32'h0};
        regVectors[16] = '{1'b0, 4'h0, A_STAT, 32'h0,        32'h2};

        burst[0] = 8'h01; burst[1] = 8'h82; burst[2] = 8'h3C;
        burst[3] = 8'hF0; burst[4] = 8'h0F; burst[5] = 8'hA5;

        reset = 1'b0;
        waitCycles(3);
        checkOutput("rstTxLine", {31'b0, uart_tx_o}, 32'd1);
        checkOutput("rstIrq",    {31'b0, irq_o},     32'd0);
        checkOutput("rstStall",  {31'b0, stall_o},   32'd0);
        checkOutput("rstData",   data_o,             32'd0);
        reset = 1'b1;
        waitCycles(1);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(regVectors[i].isWrite, regVectors[i].we, regVectors[i].addr,
                          regVectors[i].wdata, rd, st);
            if (!regVectors[i].isWrite)
                checkOutput($sformatf("regVec%0d", i), rd, regVectors[i].expData);
        end

        // Single byte: busy while framing, idle afterwards.
        txExpect.push_back(8'h55);
        busWrite(A_TX, 32'h55, st);
        waitCycles(8);
        busRead(A_STAT, rd);
        checkOutput("txBusyStatus", rd, 32'h12);
        waitTxDrain("txDrainSingle", 300);
        waitCycles(4);
        busRead(A_STAT, rd);
        checkOutput("txIdleStatus", rd, 32'h2);

        // Six back-to-back writes: the sixth stalls until the second byte is popped.
        txStartLog.delete();
        for (int i = 0; i < 6; i++) begin
            txExpect.push_back(burst[i]);
            busWrite(A_TX, {24'b0, burst[i]}, stalls[i]);
        end
        for (int i = 0; i < 5; i++) checkOutput($sformatf("noStall%0d", i), stalls[i], 32'd0);
        checkOutput("stallCycles", stalls[5], 32'd38);
        busRead(A_STAT, rd);
        checkOutput("fullStatus", rd, 32'h11);
        waitTxDrain("txDrainBurst", 400);
        checkOutput("burstFrames", txStartLog.size(), 32'd6);
        for (int i = 1; i < txStartLog.size(); i++)
            checkOutput($sformatf("burstGap%0d", i), txStartLog[i] - txStartLog[i-1], FRAME);
        waitCycles(4);
        busRead(A_STAT, rd);
        checkOutput("burstIdleStatus", rd, 32'h2);

        // Receive with interrupts enabled.
        busWrite(A_CTRL, 32'h1, st);
        sendRxFrame(8'hA3, 1'b1);
        waitCycles(3);
        checkOutput("irqOnRx", {31'b0, irq_o}, 32'd1);
        busRead(A_STAT, rd);
        checkOutput("rxValidStatus", rd, 32'h6);
        busRead(A_RX, rd);
        checkOutput("rxData", rd, 32'h800000A3);
        busRead(A_STAT, rd);
        checkOutput("rxClearedStatus", rd, 32'h2);
        pulseAck();
        checkOutput("irqAcked", {31'b0, irq_o}, 32'd0);

        // Two unread frames: overrun, plus an ack landing on the same cycle as the second set.
        sendRxFrame(8'h11, 1'b1);
        waitCycles(3);
        checkOutput("irqFirst", {31'b0, irq_o}, 32'd1);
        pulseAck();
        checkOutput("irqFirstAcked", {31'b0, irq_o}, 32'd0);
        sendRxFrame(8'h22, 1'b1);
        @(negedge clk);
        pulseAck();
        checkOutput("irqSetWinsAck", {31'b0, irq_o}, 32'd1);
        busRead(A_STAT, rd);
        checkOutput("overrunStatus", rd, 32'hE);
        busRead(A_STAT, rd);
        checkOutput("overrunCleared", rd, 32'h6);
        busWrite(A_CTRL, 32'h0, st);
        checkOutput("irqHeldAfterDisable", {31'b0, irq_o}, 32'd1);
        busRead(A_RX, rd);
        checkOutput("rxOverwritten", rd, 32'h80000022);
        busRead(A_STAT, rd);
        checkOutput("rxDrainedStatus", rd, 32'h2);
        pulseAck();
        checkOutput("irqFinalAck", {31'b0, irq_o}, 32'd0);

        // Glitch and framing error are both discarded.
        uart_rx_i = 1'b0;
        @(negedge clk);
        uart_rx_i = 1'b1;
        waitCycles(12);
        busRead(A_STAT, rd);
        checkOutput("glitchIgnored", rd, 32'h2);
        sendRxFrame(8'h5A, 1'b0);
        waitCycles(3);
        busRead(A_STAT, rd);
        checkOutput("framingDiscard", rd, 32'h2);
        busRead(A_RX, rd);
        checkOutput("framingKeepsByte", rd, 32'h22);

        // Reset in the middle of a TX frame, with a read in flight and irq pending.
        busWrite(A_CTRL, 32'h1, st);
        sendRxFrame(8'h3C, 1'b1);
        waitCycles(3);
        checkOutput("irqBeforeReset", {31'b0, irq_o}, 32'd1);
        busWrite(A_TX, 32'h00, st);
        waitCycles(10);
        checkOutput("txLowMidFrame", {31'b0, uart_tx_o}, 32'd0);
        en_i   = 1'b1;
        we_i   = 4'h0;
        addr_i = A_STAT;
        reset  = 1'b0;
        @(negedge clk);
        en_i   = 1'b0;
        addr_i = 4'h0;
        checkOutput("midRstTxLine", {31'b0, uart_tx_o}, 32'd1);
        checkOutput("midRstIrq",    {31'b0, irq_o},     32'd0);
        checkOutput("midRstData",   data_o,             32'd0);
        checkOutput("midRstStall",  {31'b0, stall_o},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        busRead(A_STAT, rd);
        checkOutput("postRstStatus", rd, 32'h2);
        busRead(A_CTRL, rd);
        checkOutput("postRstCtrl", rd, 32'h0);
        busRead(A_RX, rd);
        checkOutput("postRstRxValid", {31'b0, rd[31]}, 32'd0);
        checkOutput("txQueueEmpty", txExpect.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

endmodule
